// File: rtl/vga_pixel_fifo.sv
// vga_pixel_fifo: single-clock pixel buffer between the capture/scaler path and
// the VGA output stage. Frame-aligned on SOF, flushed on vsync falling edge,
// one pixel per read strobe with a registered (latency 1) read port.
// Optional build macro VGA_PIX_FIFO_STATS_EN adds saturating underflow/drop counters.
module vga_pixel_fifo #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 24,
    parameter int AFULL_LVL = 1008
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [DATA_W-1:0] iWR_DATA,
    input  logic              iWR_VALID,
    input  logic              iWR_SOF,
    output logic              oWR_READY,
    input  logic              iREAD,
    input  logic              iFRAME_SYNC,
    output logic [7:0]        oRed,
    output logic [7:0]        oGreen,
    output logic [7:0]        oBlue,
    output logic              oRD_VALID,
    output logic [ADDR_W:0]   oUSEDW,
    output logic              oEMPTY,
    output logic              oAFULL,
    output logic              oUNDERFLOW,
    input  logic              iCLR_ERR
`ifdef VGA_PIX_FIFO_STATS_EN
    ,
    output logic [15:0]       oUFLOW_CNT,
    output logic [15:0]       oDROP_CNT
`endif
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(AFULL_LVL);

    typedef enum logic [1:0] {StSync, StRun, StFlush} fifoState_t;

    fifoState_t        state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] pix;
    logic [ADDR_W-1:0] wrPtr, rdPtr;
    logic [ADDR_W:0]   usedw, usedwNext;
    logic              syncDly;
    logic              frameFall, doWrite, doRead, uflowEvt;

    assign oUSEDW = usedw;
    assign oEMPTY = (usedw == '0);
    assign oAFULL = (usedw >= AFULL_CNT);
    assign {oRed, oGreen, oBlue} = pix;

    // Handshake qualifiers; SYNC only lets the SOF beat through, FLUSH has ready low
    always_comb begin
        frameFall = syncDly & ~iFRAME_SYNC;
        doWrite   = iWR_VALID & oWR_READY & ((state == StRun) | ((state == StSync) & iWR_SOF));
        doRead    = iREAD & ~oEMPTY;
        uflowEvt  = iREAD & oEMPTY;
        usedwNext = usedw + (ADDR_W+1)'(doWrite) - (ADDR_W+1)'(doRead);
    end

    // Frame FSM with registered ready; a vsync fall clears the FIFO ahead of everything else
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state     <= StSync;
            oWR_READY <= 1'b0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            usedw     <= '0;
            syncDly   <= 1'b1;
        end else begin
            syncDly <= iFRAME_SYNC;
            if (frameFall) begin
                state     <= StFlush;
                oWR_READY <= 1'b0;
                wrPtr     <= '0;
                rdPtr     <= '0;
                usedw     <= '0;
            end else begin
                if (doWrite) wrPtr <= wrPtr + ADDR_W'(1);
                if (doRead)  rdPtr <= rdPtr + ADDR_W'(1);
                usedw <= usedwNext;
                case (state)
                    StSync: begin
                        // FIFO is always empty here, so ready stays high even after SOF lands
                        oWR_READY <= 1'b1;
                        if (doWrite) state <= StRun;
                    end
                    StRun: begin
                        oWR_READY <= (usedwNext != FULL_CNT);
                    end
                    default: begin
                        state     <= StSync;
                        oWR_READY <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Pixel storage write port
    always_ff @(posedge iCLK) begin
        if (doWrite) mem[wrPtr] <= iWR_DATA;
    end

    // Registered read port: popped pixel, black on underflow, hold when idle
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            pix       <= '0;
            oRD_VALID <= 1'b0;
        end else begin
            oRD_VALID <= doRead;
            if (doRead)     pix <= mem[rdPtr];
            else if (iREAD) pix <= '0;
        end
    end

    // Sticky underflow; a fresh underflow wins over a same-cycle clear
    always_ff @(posedge iCLK) begin
        if (iRST) oUNDERFLOW <= 1'b0;
        else      oUNDERFLOW <= (oUNDERFLOW & ~iCLR_ERR) | uflowEvt;
    end

`ifdef VGA_PIX_FIFO_STATS_EN
    logic dropEvt;

    function automatic logic [15:0] satInc(input logic [15:0] c, input logic inc);
        return (inc && c != 16'hFFFF) ? c + 16'd1 : c;
    endfunction

    // Beats thrown away while waiting for a frame start or during the flush cycle
    always_comb begin
        dropEvt = iWR_VALID & ((state == StFlush) | ((state == StSync) & oWR_READY & ~iWR_SOF));
    end

    // Saturating event counters, cleared together with the sticky flag
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oUFLOW_CNT <= '0;
            oDROP_CNT  <= '0;
        end else begin
            oUFLOW_CNT <= satInc(iCLR_ERR ? 16'd0 : oUFLOW_CNT, uflowEvt);
            oDROP_CNT  <= satInc(iCLR_ERR ? 16'd0 : oDROP_CNT, dropEvt);
        end
    end
`endif

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// tb_vga_pixel_fifo: scoreboard bench for vga_pixel_fifo. A queue holds the
// pixels the FIFO should contain; reads pop it and compare the RGB output.
module tb_vga_pixel_fifo;

    logic        iCLK = 1'b0;
    logic        iRST, iWR_VALID, iWR_SOF, iREAD, iFRAME_SYNC, iCLR_ERR;
    logic [23:0] iWR_DATA;
    logic        oWR_READY, oRD_VALID, oEMPTY, oAFULL, oUNDERFLOW;
    logic [7:0]  oRed, oGreen, oBlue;
    logic [10:0] oUSEDW;
`ifdef VGA_PIX_FIFO_STATS_EN
    logic [15:0] oUFLOW_CNT, oDROP_CNT;
`endif

    always #5 iCLK = ~iCLK;

    vga_pixel_fifo dut (
        .iCLK(iCLK), .iRST(iRST), .iWR_DATA(iWR_DATA), .iWR_VALID(iWR_VALID),
        .iWR_SOF(iWR_SOF), .oWR_READY(oWR_READY), .iREAD(iREAD), .iFRAME_SYNC(iFRAME_SYNC),
        .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oRD_VALID(oRD_VALID),
        .oUSEDW(oUSEDW), .oEMPTY(oEMPTY), .oAFULL(oAFULL), .oUNDERFLOW(oUNDERFLOW),
        .iCLR_ERR(iCLR_ERR)
`ifdef VGA_PIX_FIFO_STATS_EN
        , .oUFLOW_CNT(oUFLOW_CNT), .oDROP_CNT(oDROP_CNT)
`endif
    );

    int          nVec = 0;
    int          nErr = 0;
    logic [23:0] sb [$];
    bit          mRun, mFlush, mReady, mUf, prevFs;
    logic [23:0] mRgb;
    int          mUfCnt, mDropCnt;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic checkAll();
        chk("ready", 32'(oWR_READY), 32'(mReady));
        chk("usedw", 32'(oUSEDW), 32'(sb.size()));
        chk("empty", 32'(oEMPTY), 32'(sb.size() == 0));
        chk("afull", 32'(oAFULL), 32'(sb.size() >= 1008));
        chk("rgb", 32'({oRed, oGreen, oBlue}), 32'(mRgb));
        chk("uflow", 32'(oUNDERFLOW), 32'(mUf));
`ifdef VGA_PIX_FIFO_STATS_EN
        chk("uflow_cnt", 32'(oUFLOW_CNT), 32'(mUfCnt));
        chk("drop_cnt", 32'(oDROP_CNT), 32'(mDropCnt));
`endif
    endtask

    task automatic doReset();
        iRST = 1'b1; iWR_VALID = 1'b0; iWR_SOF = 1'b0; iWR_DATA = '0;
        iREAD = 1'b0; iFRAME_SYNC = 1'b1; iCLR_ERR = 1'b0;
        @(posedge iCLK); #1;
        iRST = 1'b0;
        sb.delete();
        mRun = 0; mFlush = 0; mReady = 0; mUf = 0; prevFs = 1;
        mRgb = '0; mUfCnt = 0; mDropCnt = 0;
        chk("rst_rdvalid", 32'(oRD_VALID), 32'd0);
        checkAll();
    endtask

    // One clock of stimulus; the model advances and every output is compared
    task automatic cyc(input bit wv, input bit sof, input logic [23:0] d, input bit rd,
                       input bit fs = 1'b1, input bit clr = 1'b0);
        bit acc, pop, uf, drop, fall;
        iWR_VALID = wv; iWR_SOF = sof; iWR_DATA = d; iREAD = rd;
        iFRAME_SYNC = fs; iCLR_ERR = clr;
        acc  = wv && mReady && (mRun || sof);
        pop  = rd && sb.size() > 0;
        uf   = rd && sb.size() == 0;
        drop = wv && (mFlush || (!mRun && mReady && !sof));
        fall = prevFs && !fs;
        @(posedge iCLK); #1;
        if (pop) mRgb = sb.pop_front();
        else if (rd) mRgb = '0;
        if (acc) begin
            sb.push_back(d);
            mRun = 1;
        end
        mUf = (mUf && !clr) || uf;
        if (clr) begin mUfCnt = 0; mDropCnt = 0; end
        if (uf && mUfCnt < 65535) mUfCnt++;
        if (drop && mDropCnt < 65535) mDropCnt++;
        if (fall) begin
            sb.delete(); mRun = 0; mFlush = 1; mReady = 0;
        end else if (mFlush) begin
            mFlush = 0; mReady = 1;
        end else if (!mRun) mReady = 1;
        else mReady = (sb.size() != 1024);
        prevFs = fs;
        chk("rdvalid", 32'(oRD_VALID), 32'(pop));
        checkAll();
    endtask

    initial begin
        // T1: SOF pixel then a second pixel, two reads
        doReset();
        cyc(0, 0, 0, 0);
        cyc(1, 1, 24'h112233, 0);
        cyc(1, 0, 24'h445566, 0);
        chk("t1_usedw2", 32'(oUSEDW), 32'd2);
        cyc(0, 0, 0, 1);
        chk("t1_px0", 32'({oRed, oGreen, oBlue}), 32'h112233);
        cyc(0, 0, 0, 1);
        chk("t1_px1", 32'({oRed, oGreen, oBlue}), 32'h445566);
        chk("t1_usedw0", 32'(oUSEDW), 32'd0);
        cyc(0, 0, 0, 0);

        // T2: beats without SOF are discarded
        doReset();
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 24'($urandom), 0);
        chk("t2_usedw", 32'(oUSEDW), 32'd0);
`ifdef VGA_PIX_FIFO_STATS_EN
        chk("t2_drops", 32'(oDROP_CNT), 32'd3);
`endif

        // T3: fill to full, extra write refused, one read reopens
        doReset();
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 1024; i++) cyc(1, i == 0, 24'(i + 24'h100), 0);
        chk("t3_ready", 32'(oWR_READY), 32'd0);
        chk("t3_usedw", 32'(oUSEDW), 32'd1024);
        cyc(1, 0, 24'hBADBAD, 0);
        cyc(0, 0, 0, 1);
        chk("t3_reopen", 32'(oWR_READY), 32'd1);
        chk("t3_first", 32'({oRed, oGreen, oBlue}), 32'h000100);
        cyc(1, 0, 24'hC0FFEE, 1);

        // T4: underflow, hold, clear, clear racing a new underflow
        doReset();
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        chk("t4_sticky", 32'(oUNDERFLOW), 32'd1);
        cyc(0, 0, 0, 0, 1, 1);
        chk("t4_cleared", 32'(oUNDERFLOW), 32'd0);
        cyc(0, 0, 0, 1, 1, 1);
        cyc(1, 1, 24'hA5A5A5, 1);
        cyc(0, 0, 0, 1);

        // T5: vsync fall flushes; read during flush underflows; resync on SOF
        doReset();
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 300; i++) cyc(1, i == 0, 24'($urandom), 0);
        chk("t5_usedw300", 32'(oUSEDW), 32'd300);
        cyc(0, 0, 0, 1, 0);
        chk("t5_flushed", 32'(oUSEDW), 32'd0);
        cyc(1, 0, 24'h777777, 1, 0);
        cyc(1, 0, 24'h888888, 0, 1);
        cyc(1, 0, 24'h999999, 0, 1);
        cyc(1, 1, 24'hABCDEF, 0, 1);
        cyc(0, 0, 0, 1);
        chk("t5_sof_px", 32'({oRed, oGreen, oBlue}), 32'hABCDEF);

        // T6: steady occupancy 5 with concurrent write+read across pointer wrap
        doReset();
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, i == 0, 24'(i), 0);
        for (int i = 5; i < 2005; i++) cyc(1, 0, 24'(i), 1);
        chk("t6_usedw", 32'(oUSEDW), 32'd5);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
        chk("t6_last", 32'({oRed, oGreen, oBlue}), 32'd2004);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
